// File: rtl/pll_lock_supervisor_if.sv
`timescale 1ns/1ps
// pll_lock_supervisor_if: PLL lock flag, PLL reset, downstream reset release
// and status of the PLL lock supervisor, grouped as one bundle.
//   slave  : the supervisor's view (drives resets and status, reads the lock flag)
//   master : the environment's view (PLL model or bench drives the lock flag)
interface pll_lock_supervisor_if;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       locked;
  logic       fault;
  logic [3:0] retry_cnt;

  modport slave (
    input  pll_lock,
    output pll_reset,
    output sys_rst_n,
    output locked,
    output fault,
    output retry_cnt
  );

  modport master (
    output pll_lock,
    input  pll_reset,
    input  sys_rst_n,
    input  locked,
    input  fault,
    input  retry_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// pll_lock_supervisor: pulses the PLL reset, waits for a lock that stays
// continuously asserted, then releases the downstream reset. Lock loss or a
// lock timeout is a failed attempt and restarts the PLL reset sequence.
// Optional build macro PLL_SUP_RETRY_LIMIT_EN: after MAX_RETRIES failed
// attempts the block parks in FAULT until reset_n; without it FAULT is
// unreachable, fault stays 0 and retries continue forever.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pll_lock_supervisor_if.slave bus
);

  localparam int RST_W = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
  localparam int TO_W  = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  // Terminal counts. The lock_s cycle that moves WAIT_LOCK into STABLE is the
  // first of the STABLE_CYCLES consecutive lock cycles, so STABLE itself only
  // has to see STABLE_CYCLES-1 more of them.
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 2);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [3:0]       retry_cnt_q, retry_cnt_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             locked_q, locked_d;
  logic             lock_s;
  logic             fail_s;

  assign lock_s = sync_q[1];

`ifdef PLL_SUP_RETRY_LIMIT_EN
  logic fault_q, fault_d;
  logic limit_hit_s;

  assign limit_hit_s = (int'(retry_cnt_q) >= (MAX_RETRIES - 1));
`else
  logic unused_max_retries_s;

  assign unused_max_retries_s = (MAX_RETRIES > 0);
`endif

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET_PLL;
      sync_q      <= 2'b00;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      retry_cnt_q <= 4'd0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
    end
  end

`ifdef PLL_SUP_RETRY_LIMIT_EN
  // Registered fault flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  // Next state, counter updates and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retry_cnt_d = retry_cnt_q;
    fail_s      = 1'b0;
    sync_d      = {sync_q[0], bus.pll_lock};

    case (state_q)
      ST_RESET_PLL: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still counts as a lock
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (to_cnt_q == TO_LAST) begin
          fail_s = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_STABLE: begin
        // Chatter is not a failed attempt: just go back and wait again
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d = ST_RUN;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          fail_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RESET_PLL;
      end
    endcase

    if (fail_s) begin
      retry_cnt_d = (retry_cnt_q == 4'd15) ? 4'd15 : (retry_cnt_q + 4'd1);
`ifdef PLL_SUP_RETRY_LIMIT_EN
      if (limit_hit_s) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_RESET_PLL;
      end
`else
      state_d = ST_RESET_PLL;
`endif
    end else begin
      retry_cnt_d = retry_cnt_q;
    end

    // Every state starts with all counters at zero
    if (state_d != state_q) begin
      rst_cnt_d = '0;
      to_cnt_d  = '0;
      stb_cnt_d = '0;
    end else begin
      state_d = state_q;
    end

    // Outputs follow the state being entered, so they change on the same edge
    pll_reset_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    locked_d    = (state_d == ST_RUN);
`ifdef PLL_SUP_RETRY_LIMIT_EN
    fault_d     = (state_d == ST_FAULT);
`endif
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.locked    = locked_q;
  assign bus.retry_cnt = retry_cnt_q;
`ifdef PLL_SUP_RETRY_LIMIT_EN
  assign bus.fault     = fault_q;
`else
  assign bus.fault     = 1'b0;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 64: PLL reset pulse width, in clk cycles, range 2..255.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: maximum cycles allowed in WAIT_LOCK, range 16..2^20.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized lock cycles required before release, range 2..2^16.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts allowed before FAULT (only used under REQ-022).
REQ-005 SHALL have port clk, input, 1: the 33.554 MHz board reference clock, the same clock that feeds the PLL input.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pll_lock, input, 1: PLL lock flag; asynchronous to clk.
REQ-008 SHALL have port pll_reset, output, 1: active-high reset driven to the PLL.
REQ-009 SHALL have port sys_rst_n, output, 1: active-low reset released to the downstream clock domains.
REQ-010 SHALL have port locked, output, 1: high only in state RUN.
REQ-011 SHALL have port fault, output, 1: high only in state FAULT.
REQ-012 SHALL have port retry_cnt, output, 4: failed-attempt count, saturating at 15.

Function
REQ-013 SHALL synchronize pll_lock through 2 flops into lock_s; all decisions SHALL use lock_s only (2-cycle input latency).
REQ-014 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT, with every output registered.
REQ-015 RESET_PLL behaviour:
- pll_reset=1, sys_rst_n=0.
- Counts exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
- pll_reset=0 on the same edge it leaves.
REQ-016 WAIT_LOCK behaviour:
- Timeout counter cleared on entry.
- lock_s=1 -> STABLE.
- Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> failed attempt.
- If both occur in the same cycle, lock_s=1 wins.
REQ-017 STABLE behaviour:
- Counts consecutive lock_s=1 cycles.
- Any lock_s=0 -> WAIT_LOCK with a fresh timeout; this is not a failed attempt.
- Count reaching STABLE_CYCLES -> RUN; sys_rst_n=1 and locked=1 on that edge.
REQ-018 RUN behaviour: lock_s=0 -> RESET_PLL, with sys_rst_n=0, locked=0 and pll_reset=1 on the next edge; this counts as a failed attempt.
REQ-019 A failed attempt SHALL increment retry_cnt (saturating at 15) and enter RESET_PLL, or FAULT per REQ-022.
REQ-020 sys_rst_n SHALL be 0 in every state except RUN; it never glitches high.
REQ-021 Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap; each is cleared on every state entry.

Configuration
REQ-022 Macro PLL_SUP_RETRY_LIMIT_EN:
- Defined: a failed attempt with retry_cnt >= MAX_RETRIES-1 SHALL enter FAULT instead. FAULT holds pll_reset=1, sys_rst_n=0, fault=1 until reset_n asserts.
- Undefined: FAULT is unreachable, fault is tied to 0, and retries continue indefinitely.

Reset
REQ-023 reset_n=0 SHALL asynchronously force the following, including mid-operation from any state:
- state=RESET_PLL;
- pll_reset=1, sys_rst_n=0, locked=0, fault=0;
- retry_cnt=0, all counters=0, sync flops=0.
REQ-024 Deassertion of reset_n SHALL be honoured on the first clk edge after it rises; RESET_PLL counting starts at that edge.

Verification
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-025 Clean lock: release reset_n, then raise pll_lock 10 cycles after pll_reset falls -> pll_reset high 4 cycles; sys_rst_n and locked rise 2+8 cycles after pll_lock rises; retry_cnt=0.
REQ-026 Lock chatter: in STABLE, drop pll_lock for 1 cycle at stable count 5 -> return to WAIT_LOCK; retry_cnt stays 0; release occurs 8 clean cycles after lock_s returns.
REQ-027 Timeout: pll_lock held 0 -> pll_reset re-pulses 32 cycles after falling; retry_cnt=1; with the macro defined, the second timeout gives fault=1 and pll_reset=1 held.
REQ-028 Lock loss in RUN: drop pll_lock -> sys_rst_n=0 and pll_reset=1 three edges later; retry_cnt increments.
REQ-029 Mid-operation reset: assert reset_n in STABLE at count 6 -> outputs at reset values immediately, without a clk edge; normal sequence on release.
REQ-030 Macro undefined: pll_lock held 0 for 20 timeouts -> retry_cnt saturates at 15, fault stays 0, pll_reset keeps re-pulsing.
